// File: rtl/new_usb_listservice_if.sv
// new_usb_listservice_if: ED request/completion handshake between list scheduler and ED processor
interface new_usb_listservice_if;
  logic ed_req_o;
  logic ed_is_bulk_o;
  logic ed_ack_i;
  logic ed_done_i;
  logic ed_td_served_i;
  logic ed_list_end_i;
  modport master(
    output ed_req_o, ed_is_bulk_o,
    input  ed_ack_i, ed_done_i, ed_td_served_i, ed_list_end_i
  );
  modport slave(
    input  ed_req_o, ed_is_bulk_o,
    output ed_ack_i, ed_done_i, ed_td_served_i, ed_list_end_i
  );
endinterface

// File: rtl/new_usb_listservice.sv
// new_usb_listservice: OHCI nonperiodic control/bulk list scheduler with CBSR ratio and CLF/BLF clearing
module new_usb_listservice (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   cbsr_i,
  input  logic                         cle_i,
  input  logic                         ble_i,
  input  logic                         clf_i,
  input  logic                         blf_i,
  input  logic                         window_open_i,
  new_usb_listservice_if.master        ed,
  output logic                         clf_clr_o,
  output logic                         blf_clr_o,
  output logic [2:0]                   ratio_cnt_o,
  output logic                         busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t     state;
  logic       req;
  logic       sel;
  logic       busy;
  logic [2:0] cnt;
  logic       ctrl_hit;
  logic       bulk_hit;
  logic       want_ctrl;
  logic       want_bulk;
  logic       prefer_bulk;
  logic       done;
  assign want_ctrl   = cle_i & clf_i;
  assign want_bulk   = ble_i & blf_i;
  assign prefer_bulk = cnt > {1'b0, cbsr_i};
  assign done        = (state == WAIT) & ed.ed_done_i;
  assign ed.ed_req_o     = req;
  assign ed.ed_is_bulk_o = sel;
  assign ratio_cnt_o     = cnt;
  assign busy_o          = busy;
  // A list pass that reached its tail without serving any TD clears that list's filled bit
  always_comb begin
    clf_clr_o = done & ~sel & ed.ed_list_end_i & ~(ctrl_hit | ed.ed_td_served_i);
    blf_clr_o = done &  sel & ed.ed_list_end_i & ~(bulk_hit | ed.ed_td_served_i);
  end
  // Scheduler FSM plus ratio counter and per-list pass tracking, all updated on ED completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      req      <= 1'b0;
      sel      <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 3'd0;
      ctrl_hit <= 1'b0;
      bulk_hit <= 1'b0;
    end else begin
      case (state)
        IDLE: if (window_open_i & (want_ctrl | want_bulk)) begin
          state <= ISSUE;
          req   <= 1'b1;
          busy  <= 1'b1;
          sel   <= (prefer_bulk & want_bulk) | ~want_ctrl;
        end
        ISSUE: if (ed.ed_ack_i) begin
          state <= WAIT;
          req   <= 1'b0;
        end
        WAIT: if (ed.ed_done_i) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (done) begin
        if (ed.ed_td_served_i) cnt <= sel ? 3'd0 : (cnt == 3'd4 ? 3'd4 : cnt + 3'd1);
        if (!sel) ctrl_hit <= ed.ed_list_end_i ? 1'b0 : (ctrl_hit | ed.ed_td_served_i);
        else bulk_hit <= ed.ed_list_end_i ? 1'b0 : (bulk_hit | ed.ed_td_served_i);
      end
    end
  end
endmodule

// File: doc/new_usb_listservice.md
# new_usb_listservice

Nonperiodic list scheduler for the OHCI host controller. It decides, ED by ED, whether the ED processor services the control list or the bulk list. It enforces the control:bulk service ratio (CBSR+1):1, honours the list-enable (CLE/BLE) and list-filled (CLF/BLF) bits, and stops issuing when the nonperiodic frame window closes. It also clears CLF/BLF when a full list pass serves no TD.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- cbsr_i  in  2  HcControl.CBSR; ratio is (cbsr_i+1) control EDs per bulk ED
- cle_i / ble_i  in  1 each  control/bulk list enable
- clf_i / blf_i  in  1 each  control/bulk list filled
- window_open_i  in  1  nonperiodic time remains in the current frame
- ed_req_o  out  1  request to ED processor to service one ED
- ed_is_bulk_o  out  1  list selector for the request (0 = control, 1 = bulk); stable while ed_req_o=1
- ed_ack_i  in  1  ED processor accepted the request
- ed_done_i  in  1  one-cycle pulse, ED processing finished
- ed_td_served_i  in  1  qualifies ed_done_i: a TD was served
- ed_list_end_i  in  1  qualifies ed_done_i: that ED was the list tail
- clf_clr_o / blf_clr_o  out  1 each  one-cycle pulse: clear CLF/BLF
- ratio_cnt_o  out  3  control EDs served since the last bulk ED
- busy_o  out  1  FSM not in IDLE

## Operation
- want_ctrl = cle_i & clf_i. want_bulk = ble_i & blf_i.
- prefer_bulk = (ratio_cnt > cbsr_i), compared in 3 bits with cbsr_i zero-extended.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when window_open_i & (want_ctrl | want_bulk). The select is registered at this transition:
  - bulk if prefer_bulk & want_bulk;
  - else control if want_ctrl;
  - else bulk.
- ISSUE: ed_req_o=1, ed_is_bulk_o held. On ed_ack_i -> WAIT. A request once raised is never withdrawn, even if the window or enables drop.
- WAIT: on ed_done_i -> IDLE.
- Ratio counter (3 bits, saturating at 4):
  - control ed_done_i with ed_td_served_i=1 -> +1;
  - bulk ed_done_i with ed_td_served_i=1 -> clear to 0;
  - other completions leave it unchanged;
  - cbsr_i is used live; a change only alters the next prefer_bulk.
- Per-list pass flags ctrl_hit and bulk_hit:
  - set by ed_done_i & ed_td_served_i on that list;
  - on ed_done_i & ed_list_end_i: if the flag, OR'd with the current ed_td_served_i, is 0, pulse that list's clr_o combinationally in the same cycle;
  - the flag is then cleared for the next pass.
- Window close: no new request is issued from IDLE. An in-flight ED completes normally.
- Both lists idle or disabled: remain in IDLE; no outputs toggle.

## Timing
- Reset values: FSM=IDLE, ed_req_o=0, ed_is_bulk_o=0, clf_clr_o=0, blf_clr_o=0, ratio_cnt_o=0, busy_o=0, ctrl_hit=bulk_hit=0.
- Asynchronous reset mid-transaction returns to IDLE immediately. The external ED processor is reset in the same domain.
- Latency:
  - request: ed_req_o rises 1 cycle after the IDLE conditions are true;
  - ack: ed_ack_i sampled high ends ISSUE at that edge;
  - done to next request: min 2 cycles (WAIT -> IDLE -> ISSUE). Clear pulses land during the done cycle, so IDLE samples the updated CLF/BLF.
- Simultaneous ed_ack_i and ed_done_i in ISSUE: illegal; ed_done_i only counts in WAIT.
- ratio_cnt_o, ed_is_bulk_o and busy_o are registered. Clear pulses are combinational from ed_done_i and state.

## Test plan
- CBSR=2, both lists filled/enabled, every ED serves a TD -> issued sequence C,C,C,B,C,C,C,B; ratio_cnt_o cycles 0..3.
- CBSR=3, only control filled -> continuous C issues; ratio_cnt_o saturates at 4. Then assert blf_i -> next issue is B and ratio_cnt_o returns to 0.
- Control pass of 3 EDs, none serving a TD, last with ed_list_end_i -> clf_clr_o pulses exactly once, in the done cycle of ED 3. Repeat with ED 2 serving a TD -> no pulse.
- window_open_i falls while in WAIT -> ED finishes, FSM returns to IDLE, no further ed_req_o until the window reopens.
- ed_ack_i held low for 10 cycles -> ed_req_o and ed_is_bulk_o stay stable throughout, even with cle_i toggled.
- rst_ni asserted in WAIT -> all outputs take reset values asynchronously. After release with lists filled, the first issue is C at ratio_cnt_o=0.
